// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// The master modport is the sequencer side; the slave modport is the
// host plus ALU side that surrounds it.
interface alu_cmd_sequencer_if;
  // Command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_func;
  logic [3:0] cmd_operand;
  logic       cmd_load;
  logic       cmd_nowb;

  // ALU operand/function drive and result return
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_func;
  logic [3:0] alu_result;
  logic [3:0] alu_flags;

  // Response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [3:0] rsp_flags;

  modport master (
    input  cmd_valid, cmd_func, cmd_operand, cmd_load, cmd_nowb,
    input  alu_result, alu_flags, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_func,
    output rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    output cmd_valid, cmd_func, cmd_operand, cmd_load, cmd_nowb,
    output alu_result, alu_flags, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_func,
    input  rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-style command master for a combinational 4-bit ALU.
// Accepts a command, drives the ALU for SETTLE_CYCLES cycles, captures
// result and flags, and hands them back over a valid/ready response.
// SETTLE_CYCLES must be in 1..15.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_cmd_sequencer_if.master  bus,
  output logic [3:0]           acc,
  output logic [CNT_W-1:0]     op_count
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StRespond} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             nowb_q;
  logic [3:0]       acc_q;
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [3:0]       alu_func_q;
  logic [3:0]       rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [CNT_W-1:0] op_count_q;

  // Sequencer FSM: accept, drive/settle, capture, respond
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      nowb_q       <= 1'b0;
      acc_q        <= 4'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_func_q   <= 4'd0;
      rsp_result_q <= 4'd0;
      rsp_flags_q  <= 4'd0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // cmd_ready is high whenever we are here out of reset
          if (bus.cmd_valid) begin
            nowb_q <= bus.cmd_nowb;
            if (bus.cmd_load) begin
              // Loads bypass the ALU; only Z and N are meaningful
              rsp_result_q <= bus.cmd_operand;
              rsp_flags_q  <= {bus.cmd_operand == 4'd0, bus.cmd_operand[3], 2'b00};
              if (!bus.cmd_nowb) acc_q <= bus.cmd_operand;
              state_q <= StRespond;
            end else begin
              alu_a_q    <= acc_q;
              alu_b_q    <= bus.cmd_operand;
              alu_func_q <= bus.cmd_func;
              cnt_q      <= SettleLoad;
              state_q    <= StDrive;
            end
          end
        end
        StDrive: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= bus.alu_flags;
            if (!nowb_q) acc_q <= bus.alu_result;
            state_q <= StRespond;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StRespond: begin
          if (bus.rsp_ready) begin
            op_count_q <= op_count_q + CNT_W'(1);
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready/valid decodes; cmd_ready also drops asynchronously with reset
  always_comb begin
    bus.cmd_ready = (state_q == StIdle) && !reset;
    bus.rsp_valid = (state_q == StRespond);
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign acc            = acc_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a table of directed commands, backpressure,
// reset abort, counter wrap and a randomized run against a reference model.
// dut0: SETTLE_CYCLES=1, CNT_W=8.  dut1: SETTLE_CYCLES=3, CNT_W=4.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst0;
  logic       rst1;
  logic [3:0] acc0;
  logic [3:0] acc1;
  logic [7:0] cnt0;
  logic [3:0] cnt1;

  alu_cmd_sequencer_if if0 ();
  alu_cmd_sequencer_if if1 ();

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut0 (
    .clk      (clk),
    .reset    (rst0),
    .bus      (if0),
    .acc      (acc0),
    .op_count (cnt0)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) dut1 (
    .clk      (clk),
    .reset    (rst1),
    .bus      (if1),
    .acc      (acc1),
    .op_count (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit ALU behaviour: returns {result, Z, N, C, V}; C on sub means no borrow
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] f);
    logic [4:0] w;
    logic [3:0] r;
    logic       c;
    logic       v;
    c = 1'b0;
    v = 1'b0;
    w = 5'd0;
    case (f)
      4'b0000: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[3:0];
        c = w[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'b0001: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[3:0];
        c = ~w[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b1000: r = a << b[1:0];
      4'b1001: r = a >> b[1:0];
      4'b1010: r = 4'($signed(a) >>> b[1:0]);
      4'b1111: r = b;
      default: r = 4'd0;
    endcase
    return {r, r == 4'd0, r[3], c, v};
  endfunction

  always_comb {if0.alu_result, if0.alu_flags} = alu_fn(if0.alu_a, if0.alu_b, if0.alu_func);
  always_comb {if1.alu_result, if1.alu_flags} = alu_fn(if1.alu_a, if1.alu_b, if1.alu_func);

  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one command on dut0 from a negedge; returns at the negedge where
  // rsp_valid is seen, with lat = accept-edge to rsp_valid edges.
  task automatic send0(input logic ld, input logic nowb, input logic [3:0] f,
                       input logic [3:0] op, input logic [3:0] acc_before, output int lat);
    int guard;
    guard = 0;
    while (!if0.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_wait: got cmd_ready=0 want 1");
    end
    if0.cmd_valid   = 1'b1;
    if0.cmd_load    = ld;
    if0.cmd_nowb    = nowb;
    if0.cmd_func    = f;
    if0.cmd_operand = op;
    @(posedge clk);
    @(negedge clk);
    // Scramble command inputs; the sequencer must ignore them now
    if0.cmd_valid   = 1'b0;
    if0.cmd_load    = 1'($urandom);
    if0.cmd_nowb    = 1'($urandom);
    if0.cmd_func    = 4'($urandom);
    if0.cmd_operand = 4'($urandom);
    lat = 1;
    while (!if0.rsp_valid && lat < 40) begin
      if (!ld) begin
        chk("drive_alu_a", if0.alu_a, acc_before);
        chk("drive_alu_b", if0.alu_b, op);
        chk("drive_alu_func", if0.alu_func, f);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release0();
    if0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic       ld;
    logic       nowb;
    logic [3:0] f;
    logic [3:0] op;
    logic [3:0] res;
    logic [3:0] flg;
    logic [3:0] acc;
  } vec_t;

  vec_t       tbl[10];
  logic [3:0] funcs[9] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
                           4'b1000, 4'b1001, 4'b1010, 4'b1111};

  initial begin
    int         lat;
    int         exp_cnt0;
    logic [3:0] macc;
    logic [3:0] exp_res;
    logic [3:0] exp_flg;
    logic [7:0] rf;
    logic       ld;
    logic       nowb;
    logic [3:0] f;
    logic [3:0] op;
    int         accepts;
    int         cyc;
    int         last_cyc;
    logic [3:0] last_op;

    total = 0;
    bad   = 0;

    //            ld    nowb  func     op     res    flags    acc
    tbl[0] = '{1'b1, 1'b0, 4'h0, 4'h3, 4'h3, 4'b0000, 4'h3};  // load 3
    tbl[1] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'h8, 4'b0101, 4'h8};  // add 5: N,V
    tbl[2] = '{1'b0, 1'b0, 4'h1, 4'h8, 4'h0, 4'b1010, 4'h0};  // sub 8: Z,C
    tbl[3] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0};  // load 0: Z
    tbl[4] = '{1'b1, 1'b0, 4'h0, 4'h5, 4'h5, 4'b0000, 4'h5};  // load 5
    tbl[5] = '{1'b0, 1'b1, 4'h1, 4'h5, 4'h0, 4'b1010, 4'h5};  // sub 5 nowb
    tbl[6] = '{1'b0, 1'b0, 4'h6, 4'hF, 4'hA, 4'b0100, 4'hA};  // xor F
    tbl[7] = '{1'b0, 1'b0, 4'h4, 4'h3, 4'h2, 4'b0000, 4'h2};  // and 3
    tbl[8] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'hC, 4'b0100, 4'h2};  // load C nowb
    tbl[9] = '{1'b0, 1'b0, 4'h5, 4'h1, 4'h3, 4'b0000, 4'h3};  // or 1

    if0.cmd_valid = 1'b0; if0.cmd_func = 4'h0; if0.cmd_operand = 4'h0;
    if0.cmd_load  = 1'b0; if0.cmd_nowb = 1'b0; if0.rsp_ready   = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_func = 4'h0; if1.cmd_operand = 4'h0;
    if1.cmd_load  = 1'b0; if1.cmd_nowb = 1'b0; if1.rsp_ready   = 1'b0;
    rst0 = 1'b1;
    rst1 = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", if0.cmd_ready, 0);
    chk("rst_rsp_valid", if0.rsp_valid, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_alu_func", if0.alu_func, 0);
    chk("rst_op_count", cnt0, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("rst_release_cmd_ready", if0.cmd_ready, 1);
    @(negedge clk);

    // Directed table on dut0
    macc     = 4'h0;
    exp_cnt0 = 0;
    for (int i = 0; i < 10; i++) begin
      send0(tbl[i].ld, tbl[i].nowb, tbl[i].f, tbl[i].op, macc, lat);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].ld ? 1 : 2);
      chk($sformatf("tbl%0d_result", i), if0.rsp_result, tbl[i].res);
      chk($sformatf("tbl%0d_flags", i), if0.rsp_flags, tbl[i].flg);
      chk($sformatf("tbl%0d_acc", i), acc0, tbl[i].acc);
      chk($sformatf("tbl%0d_cmd_ready", i), if0.cmd_ready, 0);
      release0();
      exp_cnt0++;
      chk($sformatf("tbl%0d_op_count", i), cnt0, exp_cnt0);
      macc = tbl[i].acc;
    end

    // Backpressure: response held, new commands refused
    send0(1'b1, 1'b0, 4'h0, 4'h9, macc, lat);
    macc = 4'h9;
    for (int k = 0; k < 5; k++) begin
      if0.cmd_valid   = 1'b1;
      if0.cmd_load    = 1'b1;
      if0.cmd_operand = 4'h4;
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", if0.rsp_valid, 1);
      chk("bp_result", if0.rsp_result, 4'h9);
      chk("bp_flags", if0.rsp_flags, 4'b0100);
      chk("bp_cmd_ready", if0.cmd_ready, 0);
      chk("bp_acc", acc0, 4'h9);
      chk("bp_op_count", cnt0, exp_cnt0);
    end
    if0.cmd_valid = 1'b0;
    release0();
    exp_cnt0++;
    chk("bp_release_op_count", cnt0, exp_cnt0);
    chk("bp_release_cmd_ready", if0.cmd_ready, 1);
    @(negedge clk);
    chk("bp_once_op_count", cnt0, exp_cnt0);
    chk("bp_stray_acc", acc0, 4'h9);

    // Randomized commands vs. reference model
    for (int n = 0; n < 40; n++) begin
      ld   = ($urandom_range(0, 3) == 0);
      nowb = ($urandom_range(0, 3) == 0);
      f    = funcs[$urandom_range(0, 8)];
      op   = 4'($urandom);
      if (ld) begin
        exp_res = op;
        exp_flg = {op == 4'd0, op[3], 2'b00};
      end else begin
        rf      = alu_fn(macc, op, f);
        exp_res = rf[7:4];
        exp_flg = rf[3:0];
      end
      send0(ld, nowb, f, op, macc, lat);
      if (!nowb) macc = exp_res;
      chk("rnd_latency", lat, ld ? 1 : 2);
      chk("rnd_result", if0.rsp_result, exp_res);
      chk("rnd_flags", if0.rsp_flags, exp_flg);
      chk("rnd_acc", acc0, macc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rnd_hold_result", if0.rsp_result, exp_res);
      release0();
      exp_cnt0++;
      chk("rnd_op_count", cnt0, 8'(exp_cnt0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // dut1 (SETTLE_CYCLES=3): load then add, latency 4
    if1.cmd_valid = 1'b1; if1.cmd_load = 1'b1; if1.cmd_operand = 4'h6;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    chk("s3_load_rsp_valid", if1.rsp_valid, 1);
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    chk("s3_load_op_count", cnt1, 1);

    if1.cmd_valid = 1'b1; if1.cmd_load = 1'b0; if1.cmd_func = 4'h0; if1.cmd_operand = 4'h2;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    lat = 1;
    while (!if1.rsp_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("s3_add_latency", lat, 4);
    chk("s3_add_result", if1.rsp_result, 4'h8);
    chk("s3_add_flags", if1.rsp_flags, 4'b0101);
    chk("s3_add_acc", acc1, 4'h8);
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.rsp_ready = 1'b0;

    // Reset in the 2nd DRIVE cycle aborts asynchronously
    if1.cmd_valid = 1'b1; if1.cmd_func = 4'h0; if1.cmd_operand = 4'h1;
    @(posedge clk);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    chk("abort_drive_rsp_valid", if1.rsp_valid, 0);
    chk("abort_drive_alu_b", if1.alu_b, 4'h1);
    @(posedge clk);
    #2 rst1 = 1'b1;
    #1;
    chk("abort_acc", acc1, 0);
    chk("abort_alu_a", if1.alu_a, 0);
    chk("abort_alu_b", if1.alu_b, 0);
    chk("abort_alu_func", if1.alu_func, 0);
    chk("abort_rsp_result", if1.rsp_result, 0);
    chk("abort_rsp_flags", if1.rsp_flags, 0);
    chk("abort_op_count", cnt1, 0);
    chk("abort_cmd_ready", if1.cmd_ready, 0);
    chk("abort_rsp_valid", if1.rsp_valid, 0);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("abort_release_cmd_ready", if1.cmd_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", if1.rsp_valid, 0);
    end

    // 17 back-to-back loads on a 4-bit counter
    if1.rsp_ready = 1'b1;
    if1.cmd_valid = 1'b1;
    if1.cmd_load  = 1'b1;
    if1.cmd_nowb  = 1'b0;
    accepts  = 0;
    cyc      = 0;
    last_cyc = 0;
    last_op  = 4'h0;
    while (accepts < 17 && cyc < 100) begin
      if1.cmd_operand = 4'(cyc + 3);
      if (if1.cmd_ready) begin
        accepts++;
        if (accepts > 1) chk("b2b_gap", cyc - last_cyc, 2);
        last_cyc = cyc;
        last_op  = if1.cmd_operand;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if1.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    chk("b2b_accepts", accepts, 17);
    chk("b2b_cycles", cyc, 33);
    chk("b2b_op_count_wrap", cnt1, 1);
    chk("b2b_acc", acc1, last_op);
    chk("b2b_idle_cmd_ready", if1.cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
